// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC, in-order request/response tracking,
// small instruction buffer toward decode, and squash of stale fetches on redirect.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [15:0] id_instruction,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_plus2,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   pc, tail_pc, target;
  logic [CW-1:0] count, outstanding, drop;
  logic [PW-1:0] head, tail;
  logic [15:0]   buf_instr [BUF_DEPTH];
  logic [15:0]   buf_pc    [BUF_DEPTH];
  logic          accept, deq, rsp, push;
  logic [CW:0]   occupancy;

  // Handshakes: a fetch is accepted when imem_req && imem_ready; decode consumes
  // the head when id_valid && !id_stall; responses return in request order.
  assign target    = redirect_pc & 16'hFFFE;
  assign deq       = id_valid && !id_stall;
  assign rsp       = imem_rvalid && (outstanding != '0);
  assign push      = rsp && (state == FETCH) && !redirect;
  assign occupancy = {1'b0, count} - (CW+1)'(deq) + {1'b0, outstanding};
  assign imem_req  = (state == FETCH) && !redirect && (occupancy < (CW+1)'(BUF_DEPTH));
  assign accept    = imem_req && imem_ready;
  assign imem_addr = pc;
  assign dbg_state = state;

  // Head is read from registers only, so no path from the memory response to decode.
  assign id_valid       = (count != '0);
  assign id_instruction = id_valid ? buf_instr[head] : 16'h0000;
  assign id_pc          = id_valid ? buf_pc[head] : 16'h0000;
  assign id_pc_plus2    = id_valid ? (buf_pc[head] + 16'd2) : 16'h0000;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (redirect && ((outstanding != '0) || accept)) state_nxt = FLUSH;
      FLUSH:   if ((drop == '0) || ((drop == CW'(1)) && rsp)) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      tail_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (redirect) begin
        pc      <= target;
        tail_pc <= target;
      end else begin
        if (accept) pc <= pc + 16'd2;
        if (push)   tail_pc <= tail_pc + 16'd2;
      end
      // In FLUSH every response still in flight belongs to the squashed stream.
      if (state == FLUSH) begin
        if (rsp && (drop != '0)) drop <= drop - CW'(1);
      end else if (redirect) begin
        drop <= outstanding + CW'(accept) - CW'(rsp);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (deq)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[tail] <= imem_rdata;
      buf_pc[tail]    <= tail_pc;
    end
  end

  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (outstanding != '0));

endmodule
